lms_weight_update: RTL



---
 rtl/lms_pkg.sv | 30 +++
 rtl/lms_weight_update_if.sv | 26 ++
 rtl/lms_tap_mac.sv | 34 +++
 rtl/lms_weight_update.sv | 89 ++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared types and constants for the LMS coefficient-update engine.
// lms_sat() is only referenced when LMS_SAT_EN is defined.
package lms_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StDone
  } lms_state_e;

  localparam int unsigned LMS_DW   = 10;
  localparam int unsigned LMS_PW   = 2 * LMS_DW;
  localparam int unsigned LMS_FRAC = 9;

  // Clamp a sign-extended value into the range of a dw-bit two's complement word.
  function automatic logic signed [31:0] lms_sat(input logic signed [31:0] v,
                                                 input int unsigned dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/lms_weight_update_if.sv
// Request/status/read-port bundle between the filter datapath and the LMS update engine.
interface lms_weight_update_if #(
  parameter int unsigned TAPS = 4,
  parameter int unsigned DW   = 10
);
  localparam int unsigned IW = $clog2(TAPS);

  logic                 start;
  logic signed [DW-1:0] err;
  logic signed [DW-1:0] x_in;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        w_rd_idx;
  logic signed [DW-1:0] w_rd_data;

  modport master (
    output start, err, x_in, w_rd_idx,
    input  busy, done, w_rd_data
  );

  modport slave (
    input  start, err, x_in, w_rd_idx,
    output busy, done, w_rd_data
  );

endinterface

// File: rtl/lms_tap_mac.sv
// Combinational per-tap update: w + ((e * x) >>> (DW-1+MU_SHIFT)).
// Define LMS_SAT_EN to clamp the sum instead of wrapping it.
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int unsigned DW       = LMS_DW,
  parameter int unsigned MU_SHIFT = 4
) (
  input  logic signed [DW-1:0] i_e,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_w,
  output logic signed [DW-1:0] o_w_next
);

  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned SHIFT = DW - 1 + MU_SHIFT;

  logic signed [PW-1:0] w_prod;
  logic signed [DW-1:0] w_delta;

  assign w_prod  = PW'(i_e) * PW'(i_x);
  // Floor rounding; the shifted product is truncated to the weight width.
  assign w_delta = DW'(w_prod >>> SHIFT);

`ifdef LMS_SAT_EN
  logic signed [DW:0] w_sum;

  assign w_sum    = (DW + 1)'(i_w) + (DW + 1)'(w_delta);
  assign o_w_next = DW'(lms_sat(32'(w_sum), DW));
`else
  assign o_w_next = i_w + w_delta;
`endif

endmodule

// File: rtl/lms_weight_update.sv
// LMS tap-weight update engine: one weight updated per cycle after each accepted start.
// Saturating weight arithmetic is selected with LMS_SAT_EN (see lms_tap_mac).
module lms_weight_update
  import lms_pkg::*;
#(
  parameter int unsigned TAPS     = 4,
  parameter int unsigned DW       = LMS_DW,
  parameter int unsigned MU_SHIFT = 4
) (
  input logic               clk,
  input logic               rst,
  lms_weight_update_if.slave bus
);

  localparam int unsigned KW = $clog2(TAPS);
  localparam logic [KW-1:0] KLast = KW'(TAPS - 1);

  lms_state_e           r_state;
  lms_state_e           w_state_next;
  logic signed [DW-1:0] r_x [TAPS];
  logic signed [DW-1:0] r_w [TAPS];
  logic signed [DW-1:0] r_e;
  logic [KW-1:0]        r_k;
  logic signed [DW-1:0] w_w_next;

  lms_tap_mac #(
    .DW       (DW),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .i_e      (r_e),
    .i_x      (r_x[r_k]),
    .i_w      (r_w[r_k]),
    .o_w_next (w_w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (bus.start) w_state_next = StUpdate;
      StUpdate: if (r_k == KLast) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state != StIdle);
    bus.done = (r_state == StDone);
  end

  // start is only honoured in StIdle, so requests while busy leave no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '{default: '0};
      r_w <= '{default: '0};
      r_e <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_x[0] <= bus.x_in;
            for (int i = 1; i < int'(TAPS); i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_e <= bus.err;
            r_k <= '0;
          end
        end
        StUpdate: begin
          r_w[r_k] <= w_w_next;
          r_k      <= (r_k == KLast) ? '0 : r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_rd_data = r_w[bus.w_rd_idx];

endmodule
